// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, lane masks
// and common constants.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_BUSY = 2'd1,
        DMEM_DONE = 2'd2
    } dmem_state_e;

    // Lane masks; bit 3 is byte offset 0 (bits 31:24 of the word).
    localparam logic [3:0] LANE_B0 = 4'b1000;
    localparam logic [3:0] LANE_B1 = 4'b0100;
    localparam logic [3:0] LANE_B2 = 4'b0010;
    localparam logic [3:0] LANE_B3 = 4'b0001;
    localparam logic [3:0] LANE_H0 = 4'b1100;
    localparam logic [3:0] LANE_H1 = 4'b0011;
    localparam logic [3:0] LANE_W  = 4'b1111;

    localparam logic        WRITE_ENABLE = 1'b1;
    localparam logic        RST_ENABLE   = 1'b0;
    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

    function automatic logic [31:0] lane_mask(input logic [3:0] lanes);
        return {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
    endfunction

endpackage

// File: rtl/dmem_bytelane_ram.sv
// Word-organised RAM with four byte-lane write enables and a registered read
// port; kept free of control logic so it maps onto block RAM.
module dmem_bytelane_ram
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [3:0]        i_we,
    input  logic              i_re,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i] == WRITE_ENABLE) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
        // Read register only moves on a committed read, so it doubles as dout storage.
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: wait-state FSM, pipeline stall request, lane-masked
// read data and out-of-range error pulse around a byte-lane RAM.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int WAIT_CYC = 2
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic        dce,
    input  logic [31:0] daddr,
    input  logic [3:0]  we,
    input  logic [3:0]  dre,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        stall_req,
    output logic        bus_err
);

    dmem_state_e       r_state;
    dmem_state_e       w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic              w_commit;
    logic              w_oor;
    logic              w_is_read;
    logic [ADDR_W-1:0] w_word;
    logic [3:0]        w_ram_we;
    logic              w_ram_re;
    logic [31:0]       w_ram_q;
    logic [3:0]        r_rd_lanes;
    logic              r_bus_err;

    assign w_oor     = (daddr >> (ADDR_W + 2)) != 32'd0;
    assign w_word    = daddr[ADDR_W+1:2];
    assign w_is_read = (we == 4'b0000) && (dre != 4'b0000);
    assign w_ram_we  = (w_commit && !w_oor) ? we : 4'b0000;
    assign w_ram_re  = w_commit && !w_oor && w_is_read;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            DMEM_IDLE: begin
                if (dce) begin
                    if (WAIT_CYC == 0) begin
                        w_state_nxt = DMEM_DONE;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = DMEM_BUSY;
                        w_cnt_nxt   = 4'(WAIT_CYC);
                    end
                end
            end
            DMEM_BUSY: begin
                // A dropped dce is a pipeline flush: abandon without committing.
                if (!dce) begin
                    w_state_nxt = DMEM_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt == 4'd1) begin
                    w_state_nxt = DMEM_DONE;
                    w_cnt_nxt   = 4'd0;
                    w_commit    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = DMEM_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state    <= DMEM_IDLE;
            r_cnt      <= 4'd0;
            r_rd_lanes <= 4'b0000;
            r_bus_err  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bus_err <= w_commit && w_oor;
            if (w_commit && w_oor) begin
                r_rd_lanes <= 4'b0000;
            end else if (w_ram_re) begin
                r_rd_lanes <= dre;
            end
        end
    end

    dmem_bytelane_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk   (cpu_clk_50M),
        .i_addr  (w_word),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_wdata (din),
        .o_rdata (w_ram_q)
    );

    assign stall_req = (cpu_rst_n != RST_ENABLE) && dce && (r_state != DMEM_DONE);
    assign dout      = (r_rd_lanes == 4'b0000) ? ZERO_WORD : (w_ram_q & lane_mask(r_rd_lanes));
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table of accesses plus hand-written
// flush and reset-mid-access sequences.
module tb_dmem_responder;

    localparam int ADDR_W   = 12;
    localparam int WAIT_CYC = 2;
    localparam int NVEC     = 16;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst_n   = 1'b0;
    logic        dce         = 1'b0;
    logic [31:0] daddr       = 32'h0;
    logic [3:0]  we          = 4'h0;
    logic [3:0]  dre         = 4'h0;
    logic [31:0] din         = 32'h0;
    logic [31:0] dout;
    logic        stall_req;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    always #10 cpu_clk_50M = ~cpu_clk_50M;

    dmem_responder #(
        .ADDR_W   (ADDR_W),
        .WAIT_CYC (WAIT_CYC)
    ) dut (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst_n   (cpu_rst_n),
        .dce         (dce),
        .daddr       (daddr),
        .we          (we),
        .dre         (dre),
        .din         (din),
        .dout        (dout),
        .stall_req   (stall_req),
        .bus_err     (bus_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [3:0]  dre;
        logic [31:0] din;
        bit          chk_dout;
        logic [31:0] exp_dout;
        logic        exp_err;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // One complete access: returns stall cycles, dout/bus_err in DONE, bus_err one cycle later.
    task automatic run_access(input logic [31:0] a, input logic [3:0] w, input logic [3:0] r,
                              input logic [31:0] d, output int ncyc, output logic [31:0] q,
                              output logic err, output logic err_after);
        @(posedge cpu_clk_50M); #1;
        dce = 1'b1; daddr = a; we = w; dre = r; din = d;
        ncyc = 0;
        #1;
        while (stall_req && ncyc < 40) begin
            ncyc++;
            @(posedge cpu_clk_50M); #1;
        end
        q   = dout;
        err = bus_err;
        @(posedge cpu_clk_50M); #1;
        dce = 1'b0; we = 4'h0; dre = 4'h0;
        err_after = bus_err;
    endtask

    initial begin
        int          ncyc;
        logic [31:0] q;
        logic        err;
        logic        err_after;

        //          addr          we     dre    din           chk  exp_dout      err
        vecs[0]  = '{32'h0000_0000, 4'hF, 4'h0, 32'h0102_0304, 0, 32'h0,         1'b0};
        vecs[1]  = '{32'h0000_0010, 4'hF, 4'h0, 32'h1122_3344, 0, 32'h0,         1'b0};
        vecs[2]  = '{32'h0000_0010, 4'h0, 4'hF, 32'h0,         1, 32'h1122_3344, 1'b0};
        vecs[3]  = '{32'h0000_0011, 4'h4, 4'h0, 32'h5555_5555, 0, 32'h0,         1'b0};
        vecs[4]  = '{32'h0000_0010, 4'h0, 4'hF, 32'h0,         1, 32'h1155_3344, 1'b0};
        vecs[5]  = '{32'h0000_0013, 4'h0, 4'h1, 32'h0,         1, 32'h0000_0044, 1'b0};
        vecs[6]  = '{32'h0000_0012, 4'h3, 4'h0, 32'hBEEF_BEEF, 0, 32'h0,         1'b0};
        vecs[7]  = '{32'h0000_0012, 4'h0, 4'h3, 32'h0,         1, 32'h0000_BEEF, 1'b0};
        vecs[8]  = '{32'h0000_0010, 4'h0, 4'hF, 32'h0,         1, 32'h1155_BEEF, 1'b0};
        vecs[9]  = '{32'h0001_0000, 4'hF, 4'h0, 32'hDEAD_BEEF, 0, 32'h0,         1'b1};
        vecs[10] = '{32'h0000_0000, 4'h0, 4'hF, 32'h0,         1, 32'h0102_0304, 1'b0};
        vecs[11] = '{32'h0001_0000, 4'h0, 4'hF, 32'h0,         1, 32'h0000_0000, 1'b1};
        vecs[12] = '{32'h0000_0010, 4'h0, 4'hF, 32'h0,         1, 32'h1155_BEEF, 1'b0};
        vecs[13] = '{32'h0000_0020, 4'hF, 4'hF, 32'hCAFE_F00D, 1, 32'h1155_BEEF, 1'b0};
        vecs[14] = '{32'h0000_0020, 4'h0, 4'hF, 32'h0,         1, 32'hCAFE_F00D, 1'b0};
        vecs[15] = '{32'h0000_0020, 4'h0, 4'h0, 32'h0,         1, 32'hCAFE_F00D, 1'b0};

        // Reset state, with a request already presented
        dce = 1'b1;
        #5;
        check("rst_stall", 0, {31'b0, stall_req}, 32'h0);
        check("rst_dout", 0, dout, 32'h0);
        check("rst_bus_err", 0, {31'b0, bus_err}, 32'h0);
        dce = 1'b0;
        #30 cpu_rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_access(vecs[i].addr, vecs[i].we, vecs[i].dre, vecs[i].din, ncyc, q, err, err_after);
            check("stall_cycles", i, ncyc, WAIT_CYC + 1);
            check("bus_err_done", i, {31'b0, err}, {31'b0, vecs[i].exp_err});
            check("bus_err_after", i, {31'b0, err_after}, 32'h0);
            if (vecs[i].chk_dout) check("dout", i, q, vecs[i].exp_dout);
        end

        // Flush: read of word 0 abandoned after one stall cycle
        @(posedge cpu_clk_50M); #1;
        dce = 1'b1; daddr = 32'h0; we = 4'h0; dre = 4'hF;
        #1 check("flush_stall_idle", 0, {31'b0, stall_req}, 32'h1);
        @(posedge cpu_clk_50M); #1;
        check("flush_stall_busy", 0, {31'b0, stall_req}, 32'h1);
        dce = 1'b0;
        #1 check("flush_stall_drop", 0, {31'b0, stall_req}, 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(posedge cpu_clk_50M); #1;
            check("flush_dout", k, dout, 32'hCAFE_F00D);
            check("flush_bus_err", k, {31'b0, bus_err}, 32'h0);
        end
        dre = 4'h0;
        run_access(32'h0000_0020, 4'h0, 4'h8, 32'h0, ncyc, q, err, err_after);
        check("post_flush_stall", 0, ncyc, WAIT_CYC + 1);
        check("post_flush_dout", 0, q, 32'hCA00_0000);

        // Reset asserted in the second stall cycle of a write
        @(posedge cpu_clk_50M); #1;
        dce = 1'b1; daddr = 32'h0000_0010; we = 4'hF; dre = 4'h0; din = 32'hAABB_CCDD;
        @(posedge cpu_clk_50M); #1;
        cpu_rst_n = 1'b0;
        #1;
        check("midrst_stall", 0, {31'b0, stall_req}, 32'h0);
        check("midrst_dout", 0, dout, 32'h0);
        #2 dce = 1'b0; we = 4'h0;
        #5 cpu_rst_n = 1'b1;
        run_access(32'h0000_0010, 4'h0, 4'hF, 32'h0, ncyc, q, err, err_after);
        check("midrst_stall_cycles", 0, ncyc, WAIT_CYC + 1);
        check("midrst_lost_write", 0, q, 32'h1155_BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the data-memory interface driven by the pipeline's memory-access stage. Accepts dce/daddr/we/dre/din requests and holds an on-chip word-organised data RAM.
- Models configurable wait states. Raises stall_req to freeze the pipeline while an access is pending, then returns lane-masked read data on dout.
- Sits between the memory-access stage and the write-back stage's load-data selection.

Parameters:
- ADDR_W, 12, word-address bits; RAM depth = 2^ADDR_W words.
- WAIT_CYC, 2, extra wait cycles per access (0..15).

Ports:
- cpu_clk_50M  in  1  clock; all state updates on the rising edge.
- cpu_rst_n  in  1  asynchronous active-low reset.
- dce  in  1  access request; held stable by the pipeline while stall_req=1.
- daddr  in  32  byte address.
- we  in  4  write byte lanes; we[3]=byte offset 0 in din[31:24], we[0]=offset 3 in din[7:0].
- dre  in  4  read byte lanes, same lane mapping as we.
- din  in  32  write data, already lane-replicated and byte-ordered by the requester.
- dout  out  32  read word in memory lane order; lanes not selected by dre read as 0.
- stall_req  out  1  pipeline freeze request.
- bus_err  out  1  one-cycle pulse: out-of-range access completed.

Behaviour:
- Reset (async, cpu_rst_n=0): state=IDLE, wait counter=0, dout=0, stall_req=0, bus_err=0. RAM contents are not cleared.
- States:
  - IDLE. On dce=1: if WAIT_CYC=0 go to DONE, else go to BUSY with cnt=WAIT_CYC.
  - BUSY. cnt decrements each cycle; when cnt=1, go to DONE.
  - DONE. Lasts 1 cycle, then returns to IDLE unconditionally. A new request is therefore sampled fresh even if it has identical fields.
- stall_req is combinational: 1 when dce=1 and state != DONE, else 0.
  - For one access, stall_req is high for WAIT_CYC+1 cycles and low in the DONE cycle.
  - The pipeline advances on the DONE-cycle edge.
- Commit point is the clock edge entering DONE:
  - Write: for each i with we[i]=1, RAM[word][8i+7:8i] <= din[8i+7:8i].
  - Read (we=0, dre!=0): dout <= RAM[word] & lane mask(dre).
- dout holds its value until the next read commits. Writes do not change dout.
- Word index = daddr[ADDR_W+1:2]. daddr[1:0] is ignored: lane selection comes only from we/dre.
- Out of range (daddr[31:ADDR_W+2] != 0): no RAM write, dout <= 0, and bus_err=1 during the DONE cycle.
- we!=0 and dre!=0 together: write wins, dre is ignored, dout unchanged.
- dce=1 with we=0 and dre=0: completes normally with no side effects.
- dce drops to 0 while in BUSY (pipeline flush on exception): abort to IDLE next edge, no write, dout unchanged, stall_req=0 immediately.
- Reset asserted mid-access: immediate IDLE. A write not yet committed is lost.
- Read-after-write to the same word in consecutive accesses returns the new data (commit precedes the next request).

Decomposition:
- Shared defines header:
  - state encodings DMEM_IDLE/DMEM_BUSY/DMEM_DONE;
  - lane mask constants (4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1100, 4'b0011, 4'b1111);
  - existing WRITE_ENABLE, RST_ENABLE and ZERO_WORD.
- One natural sub-module: dmem_bytelane_ram. Parameterised ADDR_W, 4 byte-lane write enables, synchronous read. It isolates RAM inference from the FSM and counter.

Test Plan:
- Reset mid-BUSY (WAIT_CYC=2), SW daddr=0x10 din=0xAABBCCDD we=1111 started, cpu_rst_n pulsed low in the 2nd stall cycle -> stall_req=0, dout=0 at once; later LW 0x10 reads the prior content, not 0xAABBCCDD.
- WAIT_CYC=2, SW daddr=0x10 din=0x11223344 we=1111, then LW daddr=0x10 dre=1111:
  - stall_req high 3 cycles per access;
  - dout=0x11223344 in the read's DONE cycle.
- SB to 0x11 din=0x55555555 we=0100, then LW 0x10 -> dout=0x11553344. LB 0x13 dre=0001 -> dout=0x00000044.
- SH 0x12 din=0xBEEFBEEF we=0011, then LH 0x12 dre=0011 -> dout=0x0000BEEF. Word 0x10 reads 0x1155BEEF.
- Flush: LW started, dce dropped after 1 stall cycle -> stall_req=0 same cycle, dout unchanged, state IDLE next edge, bus_err=0.
- Out of range, ADDR_W=12: SW daddr=0x00010000 -> bus_err pulses 1 cycle in DONE, word 0 unchanged. LW at the same address -> dout=0.
